// File: rtl/nibble_add_sched.sv
// Two-requester arbiter/sequencer running wide adds as NIBBLES steps through one 4-bit adder.
// Define NIBBLE_SCHED_FIXED_PRIO_EN for strict requester-0 priority instead of round-robin.
module nibble_add_sched #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_n;
    logic [W-1:0]     a_q, a_n, b_q, b_n, sum_n;
    logic             carry_q, carry_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             valid_n, id_n, cout_n;
    logic             grant1, accept0, accept1;
    logic [SH_W-1:0]  sh;
    logic [3:0]       nib_a, nib_b;
    logic [4:0]       step;
    logic [W-1:0]     nib_mask, nib_val;

`ifdef NIBBLE_SCHED_FIXED_PRIO_EN
    assign grant1 = req1_valid & ~req0_valid;
`else
    logic last_grant, last_grant_n;
    // On contention the requester that did not win last time is served
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
`endif

    // Ready is forced low while reset is asserted
    assign accept0    = rst & (state == IDLE) & req0_valid & ~grant1;
    assign accept1    = rst & (state == IDLE) & grant1;
    assign req0_ready = accept0;
    assign req1_ready = accept1;

    // One ripple step on nibble idx_q
    assign sh       = {idx_q, 2'b00};
    assign nib_a    = 4'(a_q >> sh);
    assign nib_b    = 4'(b_q >> sh);
    assign step     = 5'(nib_a) + 5'(nib_b) + 5'(carry_q);
    assign nib_mask = W'(4'hF) << sh;
    assign nib_val  = W'(step[3:0]) << sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
`ifndef NIBBLE_SCHED_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            carry_q    <= carry_n;
            idx_q      <= idx_n;
            rsp_valid  <= valid_n;
            rsp_id     <= id_n;
            rsp_sum    <= sum_n;
            rsp_cout   <= cout_n;
`ifndef NIBBLE_SCHED_FIXED_PRIO_EN
            last_grant <= last_grant_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        a_n          = a_q;
        b_n          = b_q;
        carry_n      = carry_q;
        idx_n        = idx_q;
        valid_n      = rsp_valid;
        id_n         = rsp_id;
        sum_n        = rsp_sum;
        cout_n       = rsp_cout;
`ifndef NIBBLE_SCHED_FIXED_PRIO_EN
        last_grant_n = last_grant;
`endif
        unique case (state)
            IDLE: begin
                if (accept0 | accept1) begin
                    a_n          = accept1 ? req1_a : req0_a;
                    b_n          = accept1 ? req1_b : req0_b;
                    carry_n      = accept1 ? req1_cin : req0_cin;
                    id_n         = accept1;
                    idx_n        = '0;
                    sum_n        = '0;
`ifndef NIBBLE_SCHED_FIXED_PRIO_EN
                    last_grant_n = accept1;
`endif
                    state_n      = ADD;
                end
            end
            ADD: begin
                sum_n   = (rsp_sum & ~nib_mask) | nib_val;
                carry_n = step[4];
                idx_n   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    cout_n  = step[4];
                    valid_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/nibble_add_sched.md
# nibble_add_sched

Sequencer and arbiter for the team's 4-bit ripple-carry adder datapath. The block accepts wide add requests from two requesters and arbitrates between them. It performs each add as `NIBBLES` successive 4-bit ripple-carry steps through one shared nibble adder, carrying between steps in a register, then returns the registered result over a valid/ready response channel. It sits between requesting blocks and the shared adder resource, so wide operands reuse one small adder.

## Interface
- `NIBBLES`, default 4, operand width in nibbles (`W = 4*NIBBLES`); legal range 1..16.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an add pending.
- `req0_a`, `req0_b` input W: requester 0 operands.
- `req0_cin` input 1: requester 0 carry-in.
- `req0_ready` output 1: requester 0 accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_cin`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer takes the result.
- `rsp_id` output 1: requester that owns the result (0/1).
- `rsp_sum` output W: `a+b+cin` modulo 2^W.
- `rsp_cout` output 1: carry out of the top nibble.

## Operation
- Requester handshake: the requester holds valid, operands and cin stable until it sees ready. Accept happens on `reqN_valid & reqN_ready` at a rising edge.
- FSM states are IDLE, ADD and DONE. Reset state is IDLE.
- **IDLE:**
  - Ready is combinational, asserted only to the granted requester, and only when its valid is high.
  - On accept, latch a, b, cin and the id, clear the nibble index and result registers, then go to ADD.
  - With no valid request, stay in IDLE.
- **ADD:** each cycle does one 4-bit ripple step.
  - Compute `{c, s} = a[4i+3:4i] + b[4i+3:4i] + carry`, where carry starts as the latched cin.
  - Write `s` into result nibble `i` and register `c` as the carry.
  - Increment `i`. After the step for `i = NIBBLES-1`, latch `c` into `rsp_cout` and go to DONE.
- **DONE:**
  - `rsp_valid = 1`; `rsp_sum`, `rsp_cout` and `rsp_id` are stable.
  - On `rsp_ready`, deassert `rsp_valid` and go to IDLE.
  - Both `reqN_ready` stay 0 in ADD and DONE.
- **Arbitration:**
  - A `last_grant` flop resets to 1, so requester 0 wins the first contention.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to `last_grant` wins.
  - `last_grant` updates only on accept.
- **Arithmetic:** the result is unsigned, and `{rsp_cout, rsp_sum}` equals the exact (W+1)-bit sum. Wrap-around appears only through `rsp_cout`.
- **Reset values:** `req0_ready = req1_ready = 0` (forced while rst is low), `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_cout = 0`, FSM IDLE, nibble index 0, carry 0.
- **Reset mid-operation:** the operation is discarded and no response is produced. An un-taken response is lost and the requester is not re-notified.
- A `reqN_valid` that drops without ready is legal and has no effect.

## Timing
- Accept at edge T. ADD occupies cycles T+1 to T+NIBBLES. `rsp_valid` rises after edge T+NIBBLES, i.e. it is visible in cycle T+NIBBLES+1.
- Latency from accept to `rsp_valid` is NIBBLES+1 cycles. For the default (NIBBLES=4) that is 5 cycles.
- `rsp_valid` is held with stable data for any number of cycles until `rsp_ready` is high.
- After the response handshake, IDLE is entered and the next accept can occur the cycle after.
  - Minimum request-to-request period is NIBBLES+2 cycles when `rsp_ready` is tied high.
- `rsp_*` outputs are registered. `reqN_ready` is combinational from state, grant and `reqN_valid`.
- With NIBBLES=1, ADD lasts exactly one cycle.

## Configuration
- `NIBBLE_SCHED_FIXED_PRIO_EN`:
  - **Defined:** strict priority. Requester 0 always wins contention, `last_grant` is not used, and requester 1 can starve.
  - **Undefined (default):** two-way round-robin as described above.

## Test plan
- Single add at default width: requester 0 sends `a=0x1234`, `b=0x0FCD`, cin=0. Required: `rsp_valid` exactly 5 cycles after accept, `rsp_sum=0x2201`, `rsp_cout=0`, `rsp_id=0`.
- Full carry ripple: requester 1 sends `a=0xFFFF`, `b=0x0000`, cin=1. Required: `rsp_sum=0x0000`, `rsp_cout=1`, `rsp_id=1`. Also send `0xFFFF+0xFFFF`, cin=1. Required: `0xFFFF`, cout=1.
- Contention: both requesters continuously valid from reset release, `rsp_ready=1`. Required: grants alternate 0,1,0,1, each result has the correct `rsp_id`, and consecutive accepts are 6 cycles apart.
- Backpressure: hold `rsp_ready=0` for 3 cycles in DONE. Required: `rsp_*` stable, both readies 0, and IDLE is entered the cycle after `rsp_ready` rises.
- Reset mid-ADD: assert rst low at accept+2. Required: all outputs go to their reset values immediately, and no `rsp_valid` follows release. The next request after release completes normally and is granted to requester 0.
- With `NIBBLE_SCHED_FIXED_PRIO_EN` defined: both requesters held valid. Required: requester 0 is granted on every accept and `req1_ready` never asserts.
